nibble_feeder: RTL and testbench
================================

# nibble_feeder

Upstream feeder for the nibble-wide split-variable datapath: accepts bytes over a valid/ready handshake, buffers them in a small FIFO, and serialises each byte into two 4-bit nibbles on a valid/ready output. Its `nib_out` drives the 4-bit `in_port` of the downstream nibble processing stage. The block exists to exercise packed and unpacked array storage and a small FSM under realistic back-pressure.

## Interface
- `DEPTH`, default 4: FIFO byte entries; power of two, ≥2.
- `LOW_FIRST`, default 1: 1 = emit byte[3:0] then byte[7:4]; 0 = high nibble first.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high (one clock; reset is asynchronous and active-high).
- `byte_data`  in  8  input byte.
- `byte_valid`  in  1  input byte present.
- `byte_ready`  out  1  FIFO can accept.
- `nib_out`  out  4  current nibble (to downstream `in_port`).
- `nib_valid`  out  1  `nib_out` is valid.
- `nib_ready`  in  1  downstream accepts nibble.
- `level`  out  $clog2(DEPTH)+1  FIFO occupancy (excludes byte held in output register).
- `stall_cnt`  out  8  saturating count of cycles with `byte_valid && !byte_ready`.

## Operation
- FIFO: DEPTH×8 unpacked storage, write/read pointers wrap modulo DEPTH.
- Write when `byte_valid && byte_ready`; `byte_ready = (level != DEPTH)`, from registers only. No pass-through: when full, a same-cycle pop does not enable a write.
- Output FSM, states:
  - EMPTY: `nib_valid`=0. If `level != 0`: pop head into output byte register, go FIRST.
  - FIRST: `nib_valid`=1, `nib_out` = first nibble per LOW_FIRST. On `nib_ready` → SECOND.
  - SECOND: `nib_valid`=1, `nib_out` = other nibble. On `nib_ready`: if `level != 0` pop and go FIRST (back-to-back, no bubble), else EMPTY.
- Simultaneous write and pop: `level` unchanged; pointers both advance.
- `nib_out` and output byte register hold stable while `nib_valid && !nib_ready`; `nib_out` is 0 in EMPTY.
- `stall_cnt` increments by 1 per stalled cycle, sticks at 255.
- `level` never exceeds DEPTH nor underflows; wrap of pointers is transparent.

## Timing
- Reset values: `nib_out`=0, `nib_valid`=0, `level`=0, `stall_cnt`=0, FSM=EMPTY, pointers=0; `byte_ready`=1 during and after reset.
- Reset asserted mid-operation: FIFO contents and held byte discarded immediately; `nib_valid` falls asynchronously.
- Latency: byte written at edge N into empty block → `nib_valid`=1 with first nibble after edge N+1 (FIFO passes through `level`=1 for one cycle).
- Sustained throughput: one byte per two cycles with `nib_ready` held high.
- With `nib_ready`=1 continuously and input faster than throughput, FIFO fills to DEPTH and `byte_ready` drops.

## Configuration
- `NIBBLE_FEEDER_PARITY_EN`:
  - Defined: extra port `nib_par` out 1, odd parity over the full held byte (1 when byte has even count of ones), registered with the byte on pop, reset 0, 0 in EMPTY.
  - Undefined: port and parity logic absent; all other behaviour identical.

## Test plan
- Reset release, write 0xA5 with `nib_ready`=1, LOW_FIRST=1 → `nib_out` 0x5 at edge+1, 0xA at edge+2, then `nib_valid`=0; `level` 1 for one cycle.
- LOW_FIRST=0, bytes 0x12,0x34 back-to-back, `nib_ready`=1 → nibbles 1,2,3,4 on consecutive cycles, no bubble.
- `nib_ready`=0, push 6 bytes with DEPTH=4 → `level` reaches 4, `byte_ready`=0, held byte in output register, `stall_cnt` counts stalled cycles; release `nib_ready` → all 5+ bytes drained in order, no loss.
- Full FIFO with simultaneous pop and `byte_valid` → no write that cycle, write succeeds next cycle; `level` 4→3→4.
- Hold `byte_valid` against full FIFO 300 cycles → `stall_cnt`=255, stays 255.
- Assert `rst` while in SECOND with `level`=2 → `nib_valid`, `level`, `nib_out` to 0 immediately; with `NIBBLE_FEEDER_PARITY_EN`, byte 0x03 → `nib_par`=1, 0x07 → 0.

Source files
------------

// File: rtl/nibble_feeder.sv
// Byte-to-nibble feeder: valid/ready byte FIFO followed by a two-nibble serialiser FSM.
// Optional odd-parity output over the held byte is enabled with `define NIBBLE_FEEDER_PARITY_EN.
`timescale 1ns/1ps

module nibble_feeder #(
   parameter int DEPTH     = 4,
   parameter bit LOW_FIRST = 1'b1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [7:0]               byte_data,
   input  logic                     byte_valid,
   output logic                     byte_ready,
   output logic [3:0]               nib_out,
   output logic                     nib_valid,
   input  logic                     nib_ready,
   output logic [$clog2(DEPTH):0]   level,
   output logic [7:0]               stall_cnt
`ifdef NIBBLE_FEEDER_PARITY_EN
   ,
   output logic                     nib_par
`endif
);

   localparam int PW = $clog2(DEPTH);
   localparam int LW = PW + 1;
   localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

   typedef enum logic [1:0] {
      ST_EMPTY,
      ST_FIRST,
      ST_SECOND
   } state_t;

   state_t          state_q, state_d;
   logic [7:0]      mem_q [DEPTH];
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]   level_q, level_d;
   logic [7:0]      hold_q, hold_d;
   logic [7:0]      stall_q, stall_d;
   logic            wr_en;
   logic            pop;
   logic            stalled;

`ifdef NIBBLE_FEEDER_PARITY_EN
   logic            par_q, par_d;
`endif

   // Ready depends only on the registered level, so a pop cannot open a slot in the same cycle.
   assign byte_ready = (level_q != FULL_LEVEL);
   assign wr_en      = byte_valid && byte_ready;
   assign stalled    = byte_valid && !byte_ready;
   assign level      = level_q;
   assign stall_cnt  = stall_q;

   always_comb begin
      state_d = state_q;
      pop     = 1'b0;
      case (state_q)
         ST_EMPTY: begin
            if (level_q != '0) begin
               pop     = 1'b1;
               state_d = ST_FIRST;
            end
         end
         ST_FIRST: begin
            if (nib_ready) begin
               state_d = ST_SECOND;
            end
         end
         ST_SECOND: begin
            if (nib_ready) begin
               if (level_q != '0) begin
                  pop     = 1'b1;
                  state_d = ST_FIRST;
               end else begin
                  state_d = ST_EMPTY;
               end
            end
         end
         default: begin
            state_d = ST_EMPTY;
         end
      endcase
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      hold_d   = hold_q;
      stall_d  = stall_q;
`ifdef NIBBLE_FEEDER_PARITY_EN
      par_d    = par_q;
`endif
      if (wr_en) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
         hold_d   = mem_q[rd_ptr_q];
`ifdef NIBBLE_FEEDER_PARITY_EN
         par_d    = ~^mem_q[rd_ptr_q];
`endif
      end
      case ({wr_en, pop})
         2'b10:   level_d = level_q + 1'b1;
         2'b01:   level_d = level_q - 1'b1;
         default: level_d = level_q;
      endcase
      if (stalled && (stall_q != 8'hFF)) begin
         stall_d = stall_q + 8'd1;
      end
   end

   always_comb begin
      nib_valid = (state_q != ST_EMPTY);
      nib_out   = 4'h0;
      case (state_q)
         ST_FIRST:  nib_out = LOW_FIRST ? hold_q[3:0] : hold_q[7:4];
         ST_SECOND: nib_out = LOW_FIRST ? hold_q[7:4] : hold_q[3:0];
         default:   nib_out = 4'h0;
      endcase
   end

`ifdef NIBBLE_FEEDER_PARITY_EN
   assign nib_par = par_q && (state_q != ST_EMPTY);
`endif

   // Storage has no reset: emptiness is tracked purely by pointers and level.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_ptr_q] <= byte_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_EMPTY;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         hold_q   <= 8'h00;
         stall_q  <= 8'h00;
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         hold_q   <= hold_d;
         stall_q  <= stall_d;
      end
   end

`ifdef NIBBLE_FEEDER_PARITY_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         par_q <= 1'b0;
      end else begin
         par_q <= par_d;
      end
   end
`endif

endmodule

// File: tb/tb_nibble_feeder.sv
// Scoreboard bench for nibble_feeder: two instances (low-first and high-first) share one stimulus stream.
`timescale 1ns/1ps

module tb_nibble_feeder;

   localparam int DEPTH = 4;
   localparam int LW    = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [7:0]    byte_data = 8'h00;
   logic          byte_valid = 1'b0;
   logic          nib_ready = 1'b0;

   logic          byte_ready_lo, byte_ready_hi;
   logic [3:0]    nib_out_lo, nib_out_hi;
   logic          nib_valid_lo, nib_valid_hi;
   logic [LW-1:0] level_lo, level_hi;
   logic [7:0]    stall_lo, stall_hi;
`ifdef NIBBLE_FEEDER_PARITY_EN
   logic          nib_par_lo, nib_par_hi;
`endif

   typedef struct packed {
      logic [3:0] nib;
      logic       par;
   } exp_t;

   exp_t q_lo[$];
   exp_t q_hi[$];
   int   vectors = 0;
   int   miscompares = 0;

   always #5 clk = ~clk;

   nibble_feeder #(.DEPTH(DEPTH), .LOW_FIRST(1'b1)) dut_lo (
      .clk(clk), .rst(rst), .byte_data(byte_data), .byte_valid(byte_valid),
      .byte_ready(byte_ready_lo), .nib_out(nib_out_lo), .nib_valid(nib_valid_lo),
      .nib_ready(nib_ready), .level(level_lo), .stall_cnt(stall_lo)
`ifdef NIBBLE_FEEDER_PARITY_EN
      , .nib_par(nib_par_lo)
`endif
   );

   nibble_feeder #(.DEPTH(DEPTH), .LOW_FIRST(1'b0)) dut_hi (
      .clk(clk), .rst(rst), .byte_data(byte_data), .byte_valid(byte_valid),
      .byte_ready(byte_ready_hi), .nib_out(nib_out_hi), .nib_valid(nib_valid_hi),
      .nib_ready(nib_ready), .level(level_hi), .stall_cnt(stall_hi)
`ifdef NIBBLE_FEEDER_PARITY_EN
      , .nib_par(nib_par_hi)
`endif
   );

   // Compare one observed value against the bench's expectation
   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Reference model: a byte becomes two nibbles in the configured order, parity odd over the byte
   function automatic void modelByte(input logic [7:0] b, input bit low_first,
                                     output exp_t first, output exp_t second);
      int lo, hi;
      logic p;
      lo = int'(b) % 16;
      hi = int'(b) / 16;
      p  = (($countones(b) % 2) == 0);
      first.nib  = 4'(low_first ? lo : hi);
      second.nib = 4'(low_first ? hi : lo);
      first.par  = p;
      second.par = p;
   endfunction

   // Drive one cycle of inputs just after the falling edge
   task automatic applyStimulus(input logic bv, input logic [7:0] bd, input logic nr);
      @(negedge clk);
      byte_valid = bv;
      byte_data  = bd;
      nib_ready  = nr;
   endtask

   // Reset both instances, flush the scoreboard and check reset values while reset is held
   task automatic applyReset();
      @(negedge clk);
      byte_valid = 1'b0;
      nib_ready  = 1'b0;
      rst        = 1'b1;
      q_lo.delete();
      q_hi.delete();
      #1;
      checkOutput("rst_nib_valid", 32'(nib_valid_lo), 32'd0);
      checkOutput("rst_nib_out", 32'(nib_out_lo), 32'd0);
      checkOutput("rst_level", 32'(level_lo), 32'd0);
      checkOutput("rst_stall_cnt", 32'(stall_lo), 32'd0);
      checkOutput("rst_byte_ready", 32'(byte_ready_lo), 32'd1);
      checkOutput("rst_nib_valid_hi", 32'(nib_valid_hi), 32'd0);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Record accepted bytes into the expected-nibble queues
   always @(negedge clk) begin : input_monitor
      exp_t e1, e2;
      #2;
      if (!rst && byte_valid && byte_ready_lo) begin
         modelByte(byte_data, 1'b1, e1, e2);
         q_lo.push_back(e1);
         q_lo.push_back(e2);
      end
      if (!rst && byte_valid && byte_ready_hi) begin
         modelByte(byte_data, 1'b0, e1, e2);
         q_hi.push_back(e1);
         q_hi.push_back(e2);
      end
   end

   // Pop and compare whenever a nibble is handed over on the coming edge
   always @(negedge clk) begin : output_monitor
      exp_t e;
      #3;
      if (!rst && nib_valid_lo && nib_ready) begin
         if (q_lo.size() == 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL sb_lo_unexpected: got nibble 0x%0h, expected none at %0t", nib_out_lo, $time);
         end else begin
            e = q_lo.pop_front();
            checkOutput("sb_nib_lo", 32'(nib_out_lo), 32'(e.nib));
`ifdef NIBBLE_FEEDER_PARITY_EN
            checkOutput("sb_par_lo", 32'(nib_par_lo), 32'(e.par));
`endif
         end
      end
      if (!rst && nib_valid_hi && nib_ready) begin
         if (q_hi.size() == 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL sb_hi_unexpected: got nibble 0x%0h, expected none at %0t", nib_out_hi, $time);
         end else begin
            e = q_hi.pop_front();
            checkOutput("sb_nib_hi", 32'(nib_out_hi), 32'(e.nib));
`ifdef NIBBLE_FEEDER_PARITY_EN
            checkOutput("sb_par_hi", 32'(nib_par_hi), 32'(e.par));
`endif
         end
      end
   end

   initial begin : watchdog
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not finish, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin : main
      int valid_cycles;
      logic [3:0] exp_seq_hi [4];
      logic [3:0] exp_seq_lo [4];

      applyReset();

      // Single byte latency: written at edge N, first nibble after N+1
      applyStimulus(1'b1, 8'hA5, 1'b1);
      applyStimulus(1'b0, 8'h00, 1'b1);
      #1;
      checkOutput("lat_level_one", 32'(level_lo), 32'd1);
      checkOutput("lat_not_valid_yet", 32'(nib_valid_lo), 32'd0);
      applyStimulus(1'b0, 8'h00, 1'b1);
      #1;
      checkOutput("lat_valid", 32'(nib_valid_lo), 32'd1);
      checkOutput("lat_first_lo", 32'(nib_out_lo), 32'h5);
      checkOutput("lat_first_hi", 32'(nib_out_hi), 32'hA);
      checkOutput("lat_level_zero", 32'(level_lo), 32'd0);
      applyStimulus(1'b0, 8'h00, 1'b1);
      #1;
      checkOutput("lat_second_lo", 32'(nib_out_lo), 32'hA);
      checkOutput("lat_second_hi", 32'(nib_out_hi), 32'h5);
      applyStimulus(1'b0, 8'h00, 1'b1);
      #1;
      checkOutput("lat_idle_valid", 32'(nib_valid_lo), 32'd0);
      checkOutput("lat_idle_nib_out", 32'(nib_out_lo), 32'd0);

      // Back-to-back bytes stream without a bubble
      applyStimulus(1'b1, 8'h12, 1'b1);
      applyStimulus(1'b1, 8'h34, 1'b1);
      exp_seq_hi = '{4'h1, 4'h2, 4'h3, 4'h4};
      exp_seq_lo = '{4'h2, 4'h1, 4'h4, 4'h3};
      valid_cycles = 0;
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b0, 8'h00, 1'b1);
         #1;
         if (nib_valid_hi) valid_cycles++;
         checkOutput("b2b_seq_hi", 32'(nib_out_hi), 32'(exp_seq_hi[i]));
         checkOutput("b2b_seq_lo", 32'(nib_out_lo), 32'(exp_seq_lo[i]));
      end
      checkOutput("b2b_no_bubble", 32'(valid_cycles), 32'd4);

      // Fill against back-pressure: 5 bytes accepted (one held, four queued), then 3 stalls
      applyReset();
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b1, 8'(8'h30 + i), 1'b0);
      end
      applyStimulus(1'b1, 8'h40, 1'b1);
      #1;
      checkOutput("fill_level_full", 32'(level_lo), 32'(DEPTH));
      checkOutput("fill_not_ready", 32'(byte_ready_lo), 32'd0);
      checkOutput("fill_stall3", 32'(stall_lo), 32'd3);
      checkOutput("fill_held_nib", 32'(nib_out_lo), 32'h0);
      applyStimulus(1'b1, 8'h41, 1'b1);
      #1;
      checkOutput("full_level_a", 32'(level_lo), 32'd4);
      checkOutput("full_stall4", 32'(stall_lo), 32'd4);
      applyStimulus(1'b1, 8'h42, 1'b0);
      #1;
      checkOutput("full_pop_no_write", 32'(level_lo), 32'd3);
      checkOutput("full_ready_again", 32'(byte_ready_lo), 32'd1);
      applyStimulus(1'b0, 8'h00, 1'b1);
      #1;
      checkOutput("full_refill", 32'(level_lo), 32'd4);
      checkOutput("full_stall5", 32'(stall_lo), 32'd5);
      for (int i = 0; i < 20; i++) begin
         applyStimulus(1'b0, 8'h00, 1'b1);
      end
      #1;
      checkOutput("drain_q_lo_empty", 32'(q_lo.size()), 32'd0);
      checkOutput("drain_q_hi_empty", 32'(q_hi.size()), 32'd0);
      checkOutput("drain_level", 32'(level_lo), 32'd0);
      checkOutput("drain_idle", 32'(nib_valid_lo), 32'd0);

      // Stall counter saturates at 255 and stays there
      applyReset();
      for (int i = 0; i < 300; i++) begin
         applyStimulus(1'b1, 8'($urandom), 1'b0);
      end
      applyStimulus(1'b1, 8'h00, 1'b0);
      #1;
      checkOutput("sat_stall_255", 32'(stall_lo), 32'd255);
      for (int i = 0; i < 10; i++) begin
         applyStimulus(1'b1, 8'h00, 1'b0);
      end
      #1;
      checkOutput("sat_stall_sticks", 32'(stall_lo), 32'd255);
      checkOutput("sat_level", 32'(level_lo), 32'(DEPTH));

      // Asynchronous reset while in the second nibble with two bytes queued
      applyReset();
      applyStimulus(1'b1, 8'h03, 1'b0);
      applyStimulus(1'b1, 8'h07, 1'b0);
      applyStimulus(1'b1, 8'hC9, 1'b0);
      applyStimulus(1'b0, 8'h00, 1'b1);
      #1;
      checkOutput("mid_first_nib", 32'(nib_out_lo), 32'h3);
`ifdef NIBBLE_FEEDER_PARITY_EN
      checkOutput("par_03", 32'(nib_par_lo), 32'd1);
`endif
      applyStimulus(1'b0, 8'h00, 1'b0);
      #1;
      checkOutput("mid_second_valid", 32'(nib_valid_lo), 32'd1);
      checkOutput("mid_level_two", 32'(level_lo), 32'd2);
      rst = 1'b1;
      q_lo.delete();
      q_hi.delete();
      #1;
      checkOutput("async_rst_valid", 32'(nib_valid_lo), 32'd0);
      checkOutput("async_rst_level", 32'(level_lo), 32'd0);
      checkOutput("async_rst_nib_out", 32'(nib_out_lo), 32'd0);
      checkOutput("async_rst_ready", 32'(byte_ready_lo), 32'd1);
      @(negedge clk);
      rst = 1'b0;
`ifdef NIBBLE_FEEDER_PARITY_EN
      applyStimulus(1'b1, 8'h07, 1'b0);
      applyStimulus(1'b0, 8'h00, 1'b0);
      applyStimulus(1'b0, 8'h00, 1'b0);
      #1;
      checkOutput("par_07", 32'(nib_par_lo), 32'd0);
`endif

      // Randomised traffic against the scoreboard
      applyReset();
      for (int i = 0; i < 500; i++) begin
         applyStimulus(($urandom_range(0, 9) < 7), 8'($urandom), ($urandom_range(0, 9) < 6));
      end
      for (int i = 0; i < 30; i++) begin
         applyStimulus(1'b0, 8'h00, 1'b1);
      end
      #1;
      checkOutput("rand_q_lo_empty", 32'(q_lo.size()), 32'd0);
      checkOutput("rand_q_hi_empty", 32'(q_hi.size()), 32'd0);
      checkOutput("rand_level", 32'(level_lo), 32'd0);
      checkOutput("rand_idle", 32'(nib_valid_hi), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
